gp_cmd_sequencer: RTL and testbench

//  Execution-side reader of the GP-engine command buffer. On start, fetches 2-word commands

---
 rtl/gp_engine_pkg.sv | 42 ++++
 rtl/gp_seq_timer.sv | 30 +++
 rtl/gp_cmd_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_gp_cmd_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_engine_pkg.sv
// Shared GP-engine definitions: command opcodes, error codes, command-word layout
// and the sequencer state encoding.
package gp_engine_pkg;

    typedef enum logic [1:0] {
        OP_END   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_WAIT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_PTR_OVF = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ABORT   = 2'b11
    } err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH0,
        S_WAIT0,
        S_FETCH1,
        S_WAIT1,
        S_EXEC,
        S_ISSUE,
        S_RESP,
        S_DELAY,
        S_NEXT,
        S_FINISH
    } seq_state_e;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 30;
    localparam int ADDR_W = 30;

    // Bus address carried by word0: the opcode bits are replaced by zeros.
    function automatic logic [31:0] cmd_bus_addr(input logic [31:0] word0);
        return {2'b00, word0[ADDR_W-1:0]};
    endfunction

endpackage

// File: rtl/gp_seq_timer.sv
// Loadable down-counter; flags the final cycle of a count (value 1).
// Shared between WAIT delays and bus response timeouts.
module gp_seq_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign last = (cnt_q == ONE);

endmodule

// File: rtl/gp_cmd_sequencer.sv
// Reads 2-word commands from the command buffer and executes them as bus writes,
// bus reads or timed waits until END, an error, or abort.
module gp_cmd_sequencer
    import gp_engine_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CMD_DEPTH    = 256,
    parameter int PTR_WIDTH    = $clog2(CMD_DEPTH),
    parameter int RESP_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PTR_WIDTH-1:0]  start_ptr,
    input  logic                  abort,
    output logic                  cmd_rd_en,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_rd_valid,
    input  logic [DATA_WIDTH-1:0] cmd_out,
    output logic                  mst_i_valid,
    output logic                  mst_i_rd0_wr1,
    output logic [31:0]           mst_i_addr,
    output logic [DATA_WIDTH-1:0] mst_i_wr_data,
    input  logic                  mst_o_ready,
    input  logic                  mst_o_rd_valid,
    input  logic [DATA_WIDTH-1:0] mst_o_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic [DATA_WIDTH-1:0] last_rd_data
);

    localparam logic [DATA_WIDTH-1:0] TMO_LOAD = DATA_WIDTH'(RESP_TIMEOUT);
    localparam logic [PTR_WIDTH-1:0]  PTR_LAST = PTR_WIDTH'(CMD_DEPTH - 1);
    localparam logic [PTR_WIDTH:0]    DEPTH_X  = (PTR_WIDTH+1)'(CMD_DEPTH);
    localparam logic [PTR_WIDTH:0]    STEP2    = (PTR_WIDTH+1)'(2);

    seq_state_e            state_q, state_d;
    logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [PTR_WIDTH-1:0]  cmd_ptr;
    logic [PTR_WIDTH:0]    ptr_step;
    logic                  ptr_wrap;
    logic                  ptr_at_end;
    logic [DATA_WIDTH-1:0] word0_q, word1_q;
    err_e                  err_q, err_d;
    logic                  abort_pend_q;
    logic                  abort_seen;
    op_e                   op;
    logic                  tmr_load, tmr_dec, tmr_last;
    logic [DATA_WIDTH-1:0] tmr_val;

    assign op         = op_e'(word0_q[OP_MSB:OP_LSB]);
    assign ptr_step   = {1'b0, ptr_q} + STEP2;
    assign ptr_wrap   = (ptr_step >= DEPTH_X);
    assign ptr_at_end = (ptr_q == PTR_LAST);
    // Abort raised this very cycle counts as well as one latched earlier.
    assign abort_seen = abort_pend_q | abort;

    gp_seq_timer #(.W(DATA_WIDTH)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .last     (tmr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            err_q        <= ERR_OK;
            abort_pend_q <= 1'b0;
            word0_q      <= '0;
            word1_q      <= '0;
            last_rd_data <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            if ((state_q == S_IDLE) || (state_q == S_FINISH)) begin
                abort_pend_q <= 1'b0;
            end else if (abort) begin
                abort_pend_q <= 1'b1;
            end
            if ((state_q == S_WAIT0) && cmd_rd_valid) word0_q <= cmd_out;
            if ((state_q == S_WAIT1) && cmd_rd_valid) word1_q <= cmd_out;
            if ((state_q == S_RESP) && mst_o_rd_valid) last_rd_data <= mst_o_rd_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_val  = TMO_LOAD;
        tmr_dec  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH0;
                    ptr_d   = {start_ptr[PTR_WIDTH-1:1], 1'b0};
                    err_d   = ERR_OK;
                end
            end
            S_FETCH0: begin
                if (ptr_at_end) begin
                    err_d   = ERR_PTR_OVF;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (cmd_rd_valid) begin
                    state_d = S_FETCH1;
                end else begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_FINISH;
                end
            end
            S_FETCH1: state_d = S_WAIT1;
            S_WAIT1: begin
                if (cmd_rd_valid) begin
                    state_d = S_EXEC;
                end else begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_FINISH;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_END: state_d = S_FINISH;
                    OP_WAIT: begin
                        tmr_load = 1'b1;
                        tmr_val  = word1_q;
                        state_d  = (word1_q == '0) ? S_NEXT : S_DELAY;
                    end
                    default: begin
                        tmr_load = 1'b1;
                        state_d  = S_ISSUE;
                    end
                endcase
            end
            // The request stays up until accepted; abort only acts after the handshake.
            S_ISSUE: begin
                if (mst_o_ready) begin
                    if (op == OP_READ) begin
                        tmr_load = 1'b1;
                        state_d  = S_RESP;
                    end else if (abort_seen) begin
                        err_d   = ERR_ABORT;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (tmr_last) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_FINISH;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_RESP: begin
                if (mst_o_rd_valid) begin
                    if (abort_seen) begin
                        err_d   = ERR_ABORT;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (tmr_last) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_FINISH;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_DELAY: begin
                if (abort_seen) begin
                    err_d   = ERR_ABORT;
                    state_d = S_FINISH;
                end else if (tmr_last) begin
                    state_d = S_NEXT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_NEXT: begin
                if (ptr_wrap) begin
                    err_d   = ERR_PTR_OVF;
                    state_d = S_FINISH;
                end else if (abort_seen) begin
                    err_d   = ERR_ABORT;
                    state_d = S_FINISH;
                end else begin
                    ptr_d   = ptr_step[PTR_WIDTH-1:0];
                    state_d = S_FETCH0;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign cmd_ptr       = (state_q == S_FETCH1) ? {ptr_q[PTR_WIDTH-1:1], 1'b1} : ptr_q;
    assign cmd_addr      = {{(ADDR_WIDTH-PTR_WIDTH){1'b0}}, cmd_ptr};
    assign cmd_rd_en     = ((state_q == S_FETCH0) && !ptr_at_end) || (state_q == S_FETCH1);
    assign mst_i_valid   = (state_q == S_ISSUE);
    assign mst_i_rd0_wr1 = (op == OP_WRITE);
    assign mst_i_addr    = cmd_bus_addr(word0_q[31:0]);
    assign mst_i_wr_data = word1_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FINISH);
    assign err           = err_q;

endmodule

// File: tb/tb_gp_cmd_sequencer.sv
// Bench for gp_cmd_sequencer: command-buffer and bus-bridge models, directed table,
// multi-cycle corner cases and randomized command programs against a cost model.
module tb_gp_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_ptr;
    logic        abort;
    logic        cmd_rd_en;
    logic [31:0] cmd_addr;
    logic        cmd_rd_valid;
    logic [31:0] cmd_out;
    logic        mst_i_valid;
    logic        mst_i_rd0_wr1;
    logic [31:0] mst_i_addr;
    logic [31:0] mst_i_wr_data;
    logic        mst_o_ready;
    logic        mst_o_rd_valid;
    logic [31:0] mst_o_rd_data;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] last_rd_data;

    gp_cmd_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_ptr      (start_ptr),
        .abort          (abort),
        .cmd_rd_en      (cmd_rd_en),
        .cmd_addr       (cmd_addr),
        .cmd_rd_valid   (cmd_rd_valid),
        .cmd_out        (cmd_out),
        .mst_i_valid    (mst_i_valid),
        .mst_i_rd0_wr1  (mst_i_rd0_wr1),
        .mst_i_addr     (mst_i_addr),
        .mst_i_wr_data  (mst_i_wr_data),
        .mst_o_ready    (mst_o_ready),
        .mst_o_rd_valid (mst_o_rd_valid),
        .mst_o_rd_data  (mst_o_rd_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .last_rd_data   (last_rd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] cbuf [256];
    bit          mem_en = 1'b1;
    bit          hang   = 1'b0;

    int          dly_rdy [16];
    int          dly_rsp [16];
    logic [31:0] rsp_dat [16];
    logic [31:0] obs_addr [16];
    logic        obs_wr   [16];
    logic [31:0] obs_data [16];
    int          ti;

    typedef struct {
        logic [7:0]  ptr;
        logic [31:0] w0;
        logic [31:0] w1;
        int          rdy;
        int          rsp;
        logic [31:0] rdat;
        int          exp_busy;
        logic [1:0]  exp_err;
        logic [31:0] exp_last;
        int          exp_txn;
    } vec_t;

    vec_t tbl [8];

    // Command buffer: read data returned exactly one cycle after the request.
    initial begin : mem_model
        logic        pv;
        logic [31:0] pd;
        cmd_rd_valid = 1'b0;
        cmd_out      = '0;
        pv           = 1'b0;
        pd           = '0;
        forever begin
            @(negedge clk);
            cmd_rd_valid = pv;
            cmd_out      = pd;
            pv           = cmd_rd_en && mem_en;
            pd           = (cmd_addr < 32'd256) ? cbuf[cmd_addr[7:0]] : 32'hXXXX_XXXX;
        end
    end

    // Bus bridge: ready after dly_rdy[ti] waiting cycles, read data after dly_rsp[ti].
    initial begin : bus_model
        int ph;
        int wc;
        ph             = 0;
        wc             = 0;
        mst_o_ready    = 1'b0;
        mst_o_rd_valid = 1'b0;
        mst_o_rd_data  = '0;
        forever begin
            @(negedge clk);
            mst_o_ready    = 1'b0;
            mst_o_rd_valid = 1'b0;
            if (!rst_n) begin
                ph = 0;
                wc = 0;
            end else if (ph == 0) begin
                if (mst_i_valid) begin
                    if (!hang && (wc >= dly_rdy[ti])) begin
                        mst_o_ready  = 1'b1;
                        obs_addr[ti] = mst_i_addr;
                        obs_wr[ti]   = mst_i_rd0_wr1;
                        obs_data[ti] = mst_i_wr_data;
                        wc           = 0;
                        if (mst_i_rd0_wr1) ti++;
                        else ph = 1;
                    end else begin
                        wc++;
                    end
                end else begin
                    wc = 0;
                end
            end else begin
                if (wc >= dly_rsp[ti]) begin
                    mst_o_rd_valid = 1'b1;
                    mst_o_rd_data  = rsp_dat[ti];
                    wc             = 0;
                    ph             = 0;
                    ti++;
                end else begin
                    wc++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_seq(input logic [7:0] p);
        @(negedge clk);
        start     = 1'b1;
        start_ptr = p;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts busy and request cycles from the first busy cycle up to and including done.
    task automatic wait_done(input int limit, output int bcnt, output int vcnt, output bit ok);
        bcnt = 0;
        vcnt = 0;
        ok   = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (busy) bcnt++;
            if (mst_i_valid) vcnt++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin : test
        int          b, v;
        bit          ok;
        logic [31:0] model_last;

        tbl[0] = '{8'd0,   32'h4000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0,         13, 2'b00, 32'h0,         1};
        tbl[1] = '{8'd4,   32'h8000_0020, 32'h0000_0000, 0, 2, 32'h1234_5678, 16, 2'b00, 32'h1234_5678, 1};
        tbl[2] = '{8'd8,   32'hC000_0000, 32'd5,         0, 0, 32'h0,         17, 2'b00, 32'h1234_5678, 0};
        tbl[3] = '{8'd12,  32'hC000_0000, 32'd0,         0, 0, 32'h0,         12, 2'b00, 32'h1234_5678, 0};
        tbl[4] = '{8'd16,  32'h4000_0300, 32'hA5A5_0001, 3, 0, 32'h0,         16, 2'b00, 32'h1234_5678, 1};
        tbl[5] = '{8'd20,  32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0,          6, 2'b00, 32'h1234_5678, 0};
        tbl[6] = '{8'd254, 32'h4123_4568, 32'h0BAD_F00D, 1, 0, 32'h0,          9, 2'b01, 32'h1234_5678, 1};
        tbl[7] = '{8'd255, 32'h4123_4568, 32'h0BAD_F00D, 1, 0, 32'h0,          9, 2'b01, 32'h1234_5678, 1};

        for (int i = 0; i < 256; i++) cbuf[i] = '0;
        for (int i = 0; i < 16; i++) begin
            dly_rdy[i] = 0;
            dly_rsp[i] = 0;
            rsp_dat[i] = '0;
        end
        ti        = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        start_ptr = '0;
        abort     = 1'b0;

        repeat (3) @(negedge clk);
        check("reset busy",         32'(busy),         32'h0);
        check("reset done",         32'(done),         32'h0);
        check("reset cmd_rd_en",    32'(cmd_rd_en),    32'h0);
        check("reset cmd_addr",     cmd_addr,          32'h0);
        check("reset mst_i_valid",  32'(mst_i_valid),  32'h0);
        check("reset mst_i_addr",   mst_i_addr,        32'h0);
        check("reset err",          32'(err),          32'h0);
        check("reset last_rd_data", last_rd_data,      32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logic [7:0] base;
            base       = {tbl[i].ptr[7:1], 1'b0};
            cbuf[base]       = tbl[i].w0;
            cbuf[base + 8'd1] = tbl[i].w1;
            if (base < 8'd254) begin
                cbuf[base + 8'd2] = '0;
                cbuf[base + 8'd3] = '0;
            end
            dly_rdy[0] = tbl[i].rdy;
            dly_rsp[0] = tbl[i].rsp;
            rsp_dat[0] = tbl[i].rdat;
            ti         = 0;
            start_seq(tbl[i].ptr);
            wait_done(300, b, v, ok);
            check($sformatf("vec%0d done seen", i),   32'(ok),  32'h1);
            check($sformatf("vec%0d busy cycles", i), 32'(b),   32'(tbl[i].exp_busy));
            check($sformatf("vec%0d err", i),         32'(err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d last_rd_data", i), last_rd_data, tbl[i].exp_last);
            check($sformatf("vec%0d bus txns", i),    32'(ti),  32'(tbl[i].exp_txn));
            if (tbl[i].exp_txn == 1) begin
                check($sformatf("vec%0d bus addr", i), obs_addr[0], {2'b00, tbl[i].w0[29:0]});
                check($sformatf("vec%0d bus dir", i),  32'(obs_wr[0]), 32'(tbl[i].w0[31:30] == 2'b01));
                if (tbl[i].w0[31:30] == 2'b01)
                    check($sformatf("vec%0d bus wdata", i), obs_data[0], tbl[i].w1);
            end
            @(negedge clk);
            check($sformatf("vec%0d idle after done", i), {30'b0, busy, done}, 32'h0);
        end

        // Bridge never accepts: request held for the full timeout, then dropped.
        cbuf[100] = 32'h4000_0100;
        cbuf[101] = 32'h1;
        cbuf[102] = '0;
        hang = 1'b1;
        ti   = 0;
        start_seq(8'd100);
        wait_done(1200, b, v, ok);
        check("timeout done seen",   32'(ok),  32'h1);
        check("timeout busy cycles", 32'(b),   32'd1030);
        check("timeout valid cycles", 32'(v),  32'd1024);
        check("timeout err",         32'(err), 32'h2);
        @(negedge clk);
        check("timeout valid dropped", 32'(mst_i_valid), 32'h0);
        hang = 1'b0;

        // Abort while the request waits for ready: handshake completes, then stop.
        cbuf[60] = 32'h4000_0044;
        cbuf[61] = 32'h55;
        cbuf[62] = 32'h4000_0048;
        cbuf[63] = 32'h1;
        cbuf[64] = '0;
        dly_rdy[0] = 6;
        ti = 0;
        start_seq(8'd60);
        fork
            wait_done(300, b, v, ok);
            begin
                repeat (7) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        join
        check("abort done seen",    32'(ok),  32'h1);
        check("abort busy cycles",  32'(b),   32'd13);
        check("abort valid cycles", 32'(v),   32'd7);
        check("abort err",          32'(err), 32'h3);
        check("abort bus txns",     32'(ti),  32'h1);
        check("abort bus addr",     obs_addr[0], 32'h0000_0044);

        // Command buffer silent after a read request.
        mem_en = 1'b0;
        start_seq(8'd0);
        wait_done(50, b, v, ok);
        check("cmd silent done seen",  32'(ok),  32'h1);
        check("cmd silent busy cycles", 32'(b),  32'd3);
        check("cmd silent err",        32'(err), 32'h2);
        mem_en = 1'b1;

        // A second start during a long WAIT must not restart the sequence.
        cbuf[40] = 32'hC000_0000;
        cbuf[41] = 32'd20;
        cbuf[42] = '0;
        dly_rdy[0] = 0;
        ti = 0;
        start_seq(8'd40);
        fork
            wait_done(300, b, v, ok);
            begin
                repeat (8) @(negedge clk);
                start     = 1'b1;
                start_ptr = 8'd0;
                @(negedge clk);
                start     = 1'b0;
            end
        join
        check("start-busy busy cycles", 32'(b),   32'd32);
        check("start-busy err",         32'(err), 32'h0);
        check("start-busy bus txns",    32'(ti),  32'h0);

        // Asynchronous reset in the middle of a WAIT.
        cbuf[80] = 32'hC000_0000;
        cbuf[81] = 32'd100;
        cbuf[82] = '0;
        start_seq(8'd80);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst-delay busy",         32'(busy),        32'h0);
        check("rst-delay done",         32'(done),        32'h0);
        check("rst-delay cmd_rd_en",    32'(cmd_rd_en),   32'h0);
        check("rst-delay mst_i_valid",  32'(mst_i_valid), 32'h0);
        check("rst-delay last_rd_data", last_rd_data,     32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (done || busy) seen = 1'b1;
            end
            check("rst-delay no done after reset", 32'(seen), 32'h0);
        end

        // Randomized programs checked against a per-command cycle-cost model.
        model_last = 32'h0;
        for (int p = 0; p < 15; p++) begin
            int          len, nt, exp_busy;
            logic [7:0]  base;
            logic [31:0] exp_addr [16];
            logic        exp_wr   [16];
            logic [31:0] exp_wd   [16];
            len      = $urandom_range(1, 4);
            base     = 8'(2 * $urandom_range(0, 100));
            exp_busy = 6;
            nt       = 0;
            for (int c = 0; c < len; c++) begin
                logic [1:0]  op;
                logic [29:0] a;
                logic [31:0] w1;
                op = 2'($urandom_range(1, 3));
                a  = 30'($urandom);
                w1 = $urandom;
                if (op == 2'b11) begin
                    w1 = 32'($urandom_range(0, 7));
                    exp_busy += int'(w1) + 6;
                end else begin
                    dly_rdy[nt]  = $urandom_range(0, 4);
                    dly_rsp[nt]  = $urandom_range(0, 4);
                    rsp_dat[nt]  = $urandom;
                    exp_addr[nt] = {2'b00, a};
                    exp_wr[nt]   = (op == 2'b01);
                    exp_wd[nt]   = w1;
                    if (op == 2'b01) begin
                        exp_busy += 7 + dly_rdy[nt];
                    end else begin
                        exp_busy += 8 + dly_rdy[nt] + dly_rsp[nt];
                        model_last = rsp_dat[nt];
                    end
                    nt++;
                end
                cbuf[base + 8'(2 * c)]     = {op, a};
                cbuf[base + 8'(2 * c + 1)] = w1;
            end
            cbuf[base + 8'(2 * len)]     = '0;
            cbuf[base + 8'(2 * len + 1)] = '0;
            ti = 0;
            start_seq(base);
            wait_done(400, b, v, ok);
            check($sformatf("rnd%0d done seen", p),    32'(ok),  32'h1);
            check($sformatf("rnd%0d busy cycles", p),  32'(b),   32'(exp_busy));
            check($sformatf("rnd%0d err", p),          32'(err), 32'h0);
            check($sformatf("rnd%0d last_rd_data", p), last_rd_data, model_last);
            check($sformatf("rnd%0d bus txns", p),     32'(ti),  32'(nt));
            for (int k = 0; k < nt; k++) begin
                check($sformatf("rnd%0d txn%0d addr", p, k), obs_addr[k], exp_addr[k]);
                check($sformatf("rnd%0d txn%0d dir", p, k),  32'(obs_wr[k]), 32'(exp_wr[k]));
                if (exp_wr[k])
                    check($sformatf("rnd%0d txn%0d wdata", p, k), obs_data[k], exp_wd[k]);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
